// File: rtl/dac_modulator.sv
// 1-bit DAC drive stage: fixed-period PWM or first-order sigma-delta from an
// offset-binary sample, with prescaled ticks and period-aligned sample/mode latching.
module dac_modulator #(
  parameter int width = 8,
  parameter int div   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [width-1:0] sample,
  output logic             pout,
  output logic             frame
);

  localparam int               PRE_W    = (div > 1) ? $clog2(div) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(div - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [width-1:0] cnt_q, cnt_d;
  logic [width-1:0] shadow_q, shadow_d;
  logic [width-1:0] acc_q, acc_d;
  logic             mode_q, mode_d;
  logic             pout_q, pout_d;
  logic             frame_q, frame_d;

  logic             tick;
  logic             start;
  logic             eff_mode;
  logic [width-1:0] acc_base;
  logic [width:0]   sd_sum;

  // Sum of accumulator and sample; the top bit is the carry that drives the pin.
  function automatic logic [width:0] sd_step(input logic [width-1:0] a,
                                             input logic [width-1:0] s);
    return {1'b0, a} + {1'b0, s};
  endfunction

  assign tick     = (pre_q == PRE_LAST);
  assign start    = tick && (cnt_q == '0);
  // At a period start the freshly latched mode already governs this tick.
  assign eff_mode = start ? mode : mode_q;

  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    pout_d   = pout_q;
    frame_d  = 1'b0;
    acc_base = acc_q;
    sd_sum   = '0;

    if (!en) begin
      pre_d  = '0;
      cnt_d  = '0;
      acc_d  = '0;
      pout_d = 1'b0;
    end else if (!tick) begin
      pre_d = pre_q + 1'b1;
    end else begin
      pre_d = '0;
      cnt_d = cnt_q + 1'b1;
      if (start) begin
        shadow_d = sample;
        mode_d   = mode;
        frame_d  = 1'b1;
        if (mode != mode_q) begin
          acc_base = '0;
        end
      end
      if (!eff_mode) begin
        pout_d = start ? (sample != '0) : (cnt_q < shadow_q);
        acc_d  = acc_base;
      end else begin
        sd_sum = sd_step(acc_base, sample);
        pout_d = sd_sum[width];
        acc_d  = sd_sum[width-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      acc_q    <= '0;
      mode_q   <= 1'b0;
      pout_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      pout_q   <= pout_d;
      frame_q  <= frame_d;
    end
  end

  assign pout  = pout_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_dac_modulator.sv
// Bench for dac_modulator: two instances (div=1, div=3) against a behavioural
// model, plus hand-computed waveform patterns for the main scenarios.
module tb_dac_modulator;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         mode;
  logic [W-1:0] sample;
  logic         pout0, frame0, pout1, frame1;

  always #5 clk = ~clk;

  dac_modulator #(.width(W), .div(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sample(sample),
    .pout(pout0), .frame(frame0)
  );

  dac_modulator #(.width(W), .div(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sample(sample),
    .pout(pout1), .frame(frame1)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int m_pre[2], m_cnt[2], m_sh[2], m_acc[2];
  bit m_mq[2], m_pout[2], m_frame[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference behaviour: counters as plain integers, carry as a threshold on the sum.
  function automatic void model_step(input int k, input int d);
    int s;
    if (rst) begin
      m_pre[k] = 0; m_cnt[k] = 0; m_sh[k] = 0; m_acc[k] = 0;
      m_mq[k] = 0; m_pout[k] = 0; m_frame[k] = 0;
    end else if (!en) begin
      m_pre[k] = 0; m_cnt[k] = 0; m_acc[k] = 0; m_pout[k] = 0; m_frame[k] = 0;
    end else if (m_pre[k] < d - 1) begin
      m_pre[k] = m_pre[k] + 1;
      m_frame[k] = 0;
    end else begin
      m_pre[k] = 0;
      m_frame[k] = (m_cnt[k] == 0);
      if (m_cnt[k] == 0) begin
        if (mode != m_mq[k]) m_acc[k] = 0;
        m_mq[k] = mode;
        m_sh[k] = int'(sample);
      end
      if (!m_mq[k]) begin
        m_pout[k] = (m_cnt[k] < m_sh[k]);
      end else begin
        s = m_acc[k] + int'(sample);
        m_pout[k] = (s >= N);
        m_acc[k] = s % N;
      end
      m_cnt[k] = (m_cnt[k] + 1) % N;
    end
  endfunction

  always @(posedge clk) begin
    model_step(0, 1);
    model_step(1, 3);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_u0_pout", pout0, m_pout[0]);
      check("model_u0_frame", frame0, m_frame[0]);
      check("model_u1_pout", pout1, m_pout[1]);
      check("model_u1_frame", frame1, m_frame[1]);
    end
  end

  task automatic capture(input int n, input int chg_at, input logic [W-1:0] chg_val,
                         output logic [31:0] pv, output logic [31:0] mv, output logic [31:0] fv);
    pv = '0; mv = '0; fv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pv[i] = pout0;
      mv[i] = m_pout[0];
      fv[i] = frame0;
      if (i == chg_at) sample = chg_val;
    end
  endtask

  initial begin
    logic [31:0] pv, mv, fv;
    int hi48, run, fc, f1, f2;

    rst = 1'b1; en = 1'b0; mode = 1'b0; sample = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_pout0", pout0, 0);
    check("reset_frame0", frame0, 0);
    check("reset_pout1", pout1, 0);
    check("reset_frame1", frame1, 0);

    // PWM at level 4: 4 high then 12 low, frame on the first high clk
    rst = 1'b0; en = 1'b1; sample = 4'd4;
    capture(32, -1, '0, pv, mv, fv);
    check("pwm4_pout", pv, 32'h000F000F);
    check("pwm4_model", mv, 32'h000F000F);
    check("pwm4_frame", fv, 32'h00010001);

    sample = 4'd0;
    capture(16, -1, '0, pv, mv, fv);
    check("pwm0_pout", pv[15:0], 16'h0000);
    check("pwm0_frame", fv[15:0], 16'h0001);
    sample = 4'd15;
    capture(16, -1, '0, pv, mv, fv);
    check("pwm15_pout", pv[15:0], 16'h7FFF);
    check("pwm15_model", mv[15:0], 16'h7FFF);

    // Level 4 -> 12 just before the cnt=6 tick
    sample = 4'd4;
    capture(32, 5, 4'd12, pv, mv, fv);
    check("midchange_pout", pv, 32'h0FFF000F);
    check("midchange_model", mv, 32'h0FFF000F);

    // Sigma-delta
    mode = 1'b1; sample = 4'd8;
    capture(16, -1, '0, pv, mv, fv);
    check("sd8_pout", pv[15:0], 16'hAAAA);
    check("sd8_model", mv[15:0], 16'hAAAA);
    check("sd8_frame", fv[15:0], 16'h0001);
    sample = 4'd4;
    capture(16, -1, '0, pv, mv, fv);
    check("sd4_pout", pv[15:0], 16'h8888);
    check("sd4_model", mv[15:0], 16'h8888);

    // Prescaled PWM on the div=3 instance
    mode = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b1; sample = 4'd2;
    hi48 = 0; run = 0; fc = 0; f1 = -1; f2 = -1;
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      if (i < 48 && pout1) hi48++;
      if (i >= 2 && i < 8 && pout1) run++;
      if (frame1) begin
        fc++;
        if (f1 < 0) f1 = i; else if (f2 < 0) f2 = i;
      end
    end
    check("div3_high_count", hi48, 6);
    check("div3_high_run", run, 6);
    check("div3_frame_count", fc, 2);
    check("div3_first_frame", f1, 2);
    check("div3_second_frame", f2, 50);

    // Disable mid-period, then re-enable
    sample = 4'd12;
    repeat (3) @(negedge clk);
    check("pre_disable_pout0", pout0, 1);
    en = 1'b0;
    @(negedge clk);
    check("disable_pout0", pout0, 0);
    check("disable_frame0", frame0, 0);
    check("disable_pout1", pout1, 0);
    check("disable_frame1", frame1, 0);
    en = 1'b1;
    @(negedge clk);
    check("reenable_frame0", frame0, 1);
    check("reenable_pout0", pout0, 1);
    repeat (2) @(negedge clk);
    check("reenable_frame1", frame1, 1);
    check("reenable_pout1", pout1, 1);

    // Reset mid-period
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_pout0", pout0, 0);
    check("midreset_frame0", frame0, 0);
    check("midreset_pout1", pout1, 0);
    check("midreset_frame1", frame1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_frame0", frame0, 1);
    check("post_reset_pout0", pout0, 1);

    // Randomized traffic, checked by the model process
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 2) == 0) sample = W'($urandom);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
